// File: rtl/car_motion_ctrl_pkg.sv
// Shared definitions for the car motion controller: FSM states, travel
// direction codes, one-hot floor constants and one-hot floor helpers.
package car_motion_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2,
        DOOR     = 2'd3
    } state_t;

    localparam logic [1:0] UD_STOP = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DOWN = 2'b10;

    localparam logic [3:0] FLOOR1 = 4'b0001;
    localparam logic [3:0] FLOOR2 = 4'b0010;
    localparam logic [3:0] FLOOR3 = 4'b0100;
    localparam logic [3:0] FLOOR4 = 4'b1000;

    // Binary floor number (0..3) of a one-hot position.
    function automatic logic [1:0] floor_to_idx(input logic [3:0] pos);
        logic [1:0] idx;
        case (pos)
            FLOOR1:  idx = 2'd0;
            FLOOR2:  idx = 2'd1;
            FLOOR3:  idx = 2'd2;
            FLOOR4:  idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Floors strictly above a one-hot position.
    function automatic logic [3:0] mask_above(input logic [3:0] pos);
        return ~(pos | (pos - 4'd1));
    endfunction

    // Floors strictly below a one-hot position.
    function automatic logic [3:0] mask_below(input logic [3:0] pos);
        return pos - 4'd1;
    endfunction

endpackage

// File: rtl/car_motion_ctrl_floor_travel_timer.sv
// Travel-time counter for one floor of car movement. Counts while the car is
// in a RUN state and no stop decision is being taken, and raises a
// terminal-count pulse on the last cycle of a floor-to-floor trip.
module car_motion_ctrl_floor_travel_timer #(
    parameter int TRAVEL_TICKS = 8,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_stop,
    output logic o_tc,
    output logic o_moving
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAVEL_TICKS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_count;

    // A stop decision freezes the trip so no shift can coincide with it.
    assign w_count  = i_run & ~i_stop;
    assign o_tc     = w_count & (r_cnt == CNT_LAST);
    assign o_moving = i_run;

    // Advance the travel counter, wrapping to zero at each floor arrival.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (!w_count || o_tc) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/car_motion_ctrl.sv
// Car motion / dispatch FSM. Moves the car one floor per travel period,
// decides on door service after each arrival, and hands the door cycle to
// the door timer via opendoor / endOpen.
module car_motion_ctrl
    import car_motion_ctrl_pkg::*;
#(
    parameter int TRAVEL_TICKS = 8,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] allReq,
    input  logic       up_need,
    input  logic       down_need,
    input  logic       endOpen,
    output logic [3:0] position,
    output logic [1:0] ud_mode,
    output logic       opendoor,
    output logic [1:0] floor_idx,
    output logic       moving,
    output logic       arrive
);

    state_t     r_state;
    logic [1:0] r_dir;
    logic [3:0] r_position;
    logic [1:0] r_ud_mode;
    logic       r_opendoor;
    logic [1:0] r_floor_idx;
    logic       r_arrive;
    logic       r_door_first;

    logic       w_in_run;
    logic       w_hit;
    logic       w_ahead;
    logic       w_at_end;
    logic       w_stop;
    logic       w_tc;
    logic       w_moving;
    logic       w_go_up;
    logic       w_go_down;
    logic [3:0] w_next_pos;

    assign w_in_run = (r_state == RUN_UP) || (r_state == RUN_DOWN);
    assign w_hit    = |(allReq & r_position);
    assign w_ahead  = (r_state == RUN_DOWN) ? |(allReq & mask_below(r_position))
                                            : |(allReq & mask_above(r_position));
    // Running into an end floor: nothing can be ahead, so stop without shifting.
    assign w_at_end = ((r_state == RUN_UP)   && (r_position == FLOOR4)) ||
                      ((r_state == RUN_DOWN) && (r_position == FLOOR1));
    assign w_stop   = w_in_run & (w_at_end | (r_arrive & (w_hit | ~w_ahead)));

    assign w_next_pos = (r_state == RUN_UP) ? {r_position[2:0], 1'b0}
                                            : {1'b0, r_position[3:1]};

    // Door-exit choice: keep the current direction if possible, else reverse;
    // with no direction held, up has priority.
    assign w_go_up   = (r_dir == UD_DOWN) ? (up_need & ~down_need) : up_need;
    assign w_go_down = (r_dir == UD_DOWN) ? down_need : (down_need & ~up_need);

    car_motion_ctrl_floor_travel_timer #(
        .TRAVEL_TICKS (TRAVEL_TICKS),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_run    (w_in_run),
        .i_stop   (w_stop),
        .o_tc     (w_tc),
        .o_moving (w_moving)
    );

    // Motion FSM: position shifting, door entry/exit and direction bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_dir        <= UD_STOP;
            r_position   <= FLOOR1;
            r_ud_mode    <= UD_STOP;
            r_opendoor   <= 1'b0;
            r_floor_idx  <= 2'd0;
            r_arrive     <= 1'b0;
            r_door_first <= 1'b0;
        end else begin
            r_arrive <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_state      <= DOOR;
                        r_dir        <= UD_STOP;
                        r_ud_mode    <= UD_STOP;
                        r_opendoor   <= 1'b1;
                        r_door_first <= 1'b1;
                    end else if (up_need) begin
                        r_state   <= RUN_UP;
                        r_dir     <= UD_UP;
                        r_ud_mode <= UD_UP;
                    end else if (down_need) begin
                        r_state   <= RUN_DOWN;
                        r_dir     <= UD_DOWN;
                        r_ud_mode <= UD_DOWN;
                    end else begin
                        r_state   <= IDLE;
                        r_dir     <= UD_STOP;
                        r_ud_mode <= UD_STOP;
                    end
                end
                RUN_UP, RUN_DOWN: begin
                    if (w_tc) begin
                        r_position  <= w_next_pos;
                        r_floor_idx <= floor_to_idx(w_next_pos);
                        r_arrive    <= 1'b1;
                    end else if (r_arrive && w_hit) begin
                        r_state      <= DOOR;
                        r_opendoor   <= 1'b1;
                        r_door_first <= 1'b1;
                    end else if (w_stop) begin
                        r_state   <= IDLE;
                        r_dir     <= UD_STOP;
                        r_ud_mode <= UD_STOP;
                    end else begin
                        r_state <= r_state;
                    end
                end
                DOOR: begin
                    // endOpen may still be high from the previous door cycle.
                    r_door_first <= 1'b0;
                    if (!r_door_first && endOpen) begin
                        r_opendoor <= 1'b0;
                        if (w_go_up) begin
                            r_state   <= RUN_UP;
                            r_dir     <= UD_UP;
                            r_ud_mode <= UD_UP;
                        end else if (w_go_down) begin
                            r_state   <= RUN_DOWN;
                            r_dir     <= UD_DOWN;
                            r_ud_mode <= UD_DOWN;
                        end else begin
                            r_state   <= IDLE;
                            r_dir     <= UD_STOP;
                            r_ud_mode <= UD_STOP;
                        end
                    end else begin
                        r_opendoor <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign position  = r_position;
    assign ud_mode   = r_ud_mode;
    // The door request is withdrawn as soon as reset is seen.
    assign opendoor  = r_opendoor & ~rst;
    assign floor_idx = r_floor_idx;
    assign moving    = w_moving;
    assign arrive    = r_arrive;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Scoreboard bench for car_motion_ctrl: stimulus pushes the expected output
// changes (cycle + tuple); a monitor pops one entry per observed change.
module tb_car_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] allReq;
    logic       up_need;
    logic       down_need;
    logic       endOpen;
    logic [3:0] position;
    logic [1:0] ud_mode;
    logic       opendoor;
    logic [1:0] floor_idx;
    logic       moving;
    logic       arrive;

    car_motion_ctrl #(.TRAVEL_TICKS(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .allReq    (allReq),
        .up_need   (up_need),
        .down_need (down_need),
        .endOpen   (endOpen),
        .position  (position),
        .ud_mode   (ud_mode),
        .opendoor  (opendoor),
        .floor_idx (floor_idx),
        .moving    (moving),
        .arrive    (arrive)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [10:0] tup;   // {pos[4], ud[2], od, idx[2], mov, arr}
    } ev_t;

    ev_t         sb[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [10:0] prev = 11'h7FF;
    logic [10:0] cur;
    ev_t         e;
    int          c;

    task automatic ev(input int at, input logic [3:0] pos, input logic [1:0] ud,
                      input logic od, input logic [1:0] idx, input logic mov,
                      input logic arr);
        ev_t x;
        x.at  = at;
        x.tup = {pos, ud, od, idx, mov, arr};
        sb.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every change of the output tuple must match the next expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {position, ud_mode, opendoor, floor_idx, moving, arrive};
                if (cur !== prev) begin
                    prev = cur;
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_change cyc=%0d got pos_ud_od_idx_mov_arr=%b required no change",
                                 cyc, cur);
                    end else begin
                        e = sb.pop_front();
                        if (e.at != cyc || e.tup !== cur) begin
                            fails++;
                            $display("FAIL out_change got cyc=%0d pos_ud_od_idx_mov_arr=%b required cyc=%0d %b",
                                     cyc, cur, e.at, e.tup);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; allReq = 4'b0000; up_need = 1'b0; down_need = 1'b0; endOpen = 1'b0;

        // Reset state
        ev(1, 4'b0001, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick(1);
        mon_en = 1'b1;
        rst = 1'b0;
        tick(1);

        // Request at floor 1 from IDLE: door, early endOpen ignored
        c = cyc;
        ev(c + 1, 4'b0001, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
        ev(c + 5, 4'b0001, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        allReq = 4'b0001;
        tick(1); allReq = 4'b0000; endOpen = 1'b1;
        tick(1); endOpen = 1'b0;
        tick(2); endOpen = 1'b1;
        tick(1); endOpen = 1'b0;
        tick(1);

        // Floor 1 -> 3, floor 2 passed, door at 3 with ud=01
        c = cyc;
        ev(c + 1,  4'b0001, 2'b01, 1'b0, 2'd0, 1'b1, 1'b0);
        ev(c + 9,  4'b0010, 2'b01, 1'b0, 2'd1, 1'b1, 1'b1);
        ev(c + 10, 4'b0010, 2'b01, 1'b0, 2'd1, 1'b1, 1'b0);
        ev(c + 17, 4'b0100, 2'b01, 1'b0, 2'd2, 1'b1, 1'b1);
        ev(c + 18, 4'b0100, 2'b01, 1'b1, 2'd2, 1'b0, 1'b0);
        ev(c + 20, 4'b0100, 2'b00, 1'b0, 2'd2, 1'b0, 1'b0);
        allReq = 4'b0100; up_need = 1'b1;
        tick(18); allReq = 4'b0000; up_need = 1'b0;
        tick(1);  endOpen = 1'b1;
        tick(1);  endOpen = 1'b0;
        tick(1);

        // Floor 3 -> 4 door (dir up), reverse to RUN_DOWN, door at floor 2
        c = cyc;
        ev(c + 1,  4'b0100, 2'b01, 1'b0, 2'd2, 1'b1, 1'b0);
        ev(c + 9,  4'b1000, 2'b01, 1'b0, 2'd3, 1'b1, 1'b1);
        ev(c + 10, 4'b1000, 2'b01, 1'b1, 2'd3, 1'b0, 1'b0);
        ev(c + 12, 4'b1000, 2'b10, 1'b0, 2'd3, 1'b1, 1'b0);
        ev(c + 20, 4'b0100, 2'b10, 1'b0, 2'd2, 1'b1, 1'b1);
        ev(c + 21, 4'b0100, 2'b10, 1'b0, 2'd2, 1'b1, 1'b0);
        ev(c + 28, 4'b0010, 2'b10, 1'b0, 2'd1, 1'b1, 1'b1);
        ev(c + 29, 4'b0010, 2'b10, 1'b1, 2'd1, 1'b0, 1'b0);
        ev(c + 31, 4'b0010, 2'b00, 1'b0, 2'd1, 1'b0, 1'b0);
        allReq = 4'b1000; up_need = 1'b1;
        tick(10); allReq = 4'b0010; up_need = 1'b0; down_need = 1'b1;
        tick(1);  endOpen = 1'b1;
        tick(1);  endOpen = 1'b0;
        tick(17); allReq = 4'b0000; down_need = 1'b0;
        tick(1);  endOpen = 1'b1;
        tick(1);  endOpen = 1'b0;
        tick(1);

        // Both needs at floor 2: up wins; ride to floor 4 door, then IDLE
        c = cyc;
        ev(c + 1,  4'b0010, 2'b01, 1'b0, 2'd1, 1'b1, 1'b0);
        ev(c + 9,  4'b0100, 2'b01, 1'b0, 2'd2, 1'b1, 1'b1);
        ev(c + 10, 4'b0100, 2'b01, 1'b0, 2'd2, 1'b1, 1'b0);
        ev(c + 17, 4'b1000, 2'b01, 1'b0, 2'd3, 1'b1, 1'b1);
        ev(c + 18, 4'b1000, 2'b01, 1'b1, 2'd3, 1'b0, 1'b0);
        ev(c + 20, 4'b1000, 2'b00, 1'b0, 2'd3, 1'b0, 1'b0);
        allReq = 4'b1000; up_need = 1'b1; down_need = 1'b1;
        tick(1);  down_need = 1'b0;
        tick(17); allReq = 4'b0000; up_need = 1'b0;
        tick(1);  endOpen = 1'b1;
        tick(1);  endOpen = 1'b0;
        tick(1);

        // up_need at floor 4: RUN_UP for one cycle, then IDLE, no shift
        c = cyc;
        ev(c + 1, 4'b1000, 2'b01, 1'b0, 2'd3, 1'b1, 1'b0);
        ev(c + 2, 4'b1000, 2'b00, 1'b0, 2'd3, 1'b0, 1'b0);
        up_need = 1'b1;
        tick(1); up_need = 1'b0;
        tick(2);

        // RUN_DOWN from floor 4, continue past floor 3, rst at travel_cnt=5
        c = cyc;
        ev(c + 1,  4'b1000, 2'b10, 1'b0, 2'd3, 1'b1, 1'b0);
        ev(c + 9,  4'b0100, 2'b10, 1'b0, 2'd2, 1'b1, 1'b1);
        ev(c + 10, 4'b0100, 2'b10, 1'b0, 2'd2, 1'b1, 1'b0);
        ev(c + 15, 4'b0001, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        allReq = 4'b0001; down_need = 1'b1;
        tick(14); rst = 1'b1;
        tick(1);  rst = 1'b0; allReq = 4'b0000; down_need = 1'b0;
        tick(2);

        // rst during door: opendoor drops in the same cycle
        c = cyc;
        ev(c + 1, 4'b0001, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
        ev(c + 3, 4'b0001, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        allReq = 4'b0001;
        tick(1); allReq = 4'b0000;
        tick(2); rst = 1'b1;
        tick(1); rst = 1'b0;
        tick(3);

        // All expected changes must have been observed
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL missing_changes got %0d pending required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
